// File: rtl/data_compare8_if.sv
// Operand/result bundle for the data_compare8 registered magnitude comparator.
// The master drives the two operands, and the slave returns the one-hot result.
interface data_compare8_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] iData_a;
   logic [WIDTH-1:0] iData_b;
   logic [2:0]       oData;

   modport master (
      output iData_a,
      output iData_b,
      input  oData
   );

   modport slave (
      input  iData_a,
      input  iData_b,
      output oData
   );
endinterface

// File: rtl/data_compare8.sv
// Registered magnitude comparator built from MSB-first cascaded 4-bit slices (74x85 style).
// Define DATA_COMPARE_SIGNED_EN for a two's-complement compare; unsigned when undefined.
module data_compare8 #(
   parameter int WIDTH   = 8,
   parameter int SLICE_W = 4
) (
   input  logic          iClk,
   input  logic          iRst_n,
   data_compare8_if.slave bus
);
   localparam int SLICES = WIDTH / SLICE_W;

`ifdef DATA_COMPARE_SIGNED_EN
   localparam bit SIGNED_EN = 1'b1;
`else
   localparam bit SIGNED_EN = 1'b0;
`endif

   if ((SLICE_W != 4) || (WIDTH < 4) || ((WIDTH % 4) != 0)) begin : gParamCheck
      $error("data_compare8: WIDTH must be a multiple of 4 (min 4) and SLICE_W must be 4");
   end

   logic [SLICES-1:0] sliceGt;
   logic [SLICES-1:0] sliceEq;
   logic [SLICES-1:0] sliceLt;

   genvar gi;
   generate
      for (gi = 0; gi < SLICES; gi++) begin : gSlice
         // Flipping the sign bit of both operands maps two's complement onto unsigned order.
         localparam logic [3:0] FLIP =
            (SIGNED_EN && (gi == SLICES - 1)) ? 4'b1000 : 4'b0000;

         logic [3:0] nibA;
         logic [3:0] nibB;

         assign nibA        = bus.iData_a[gi*4 +: 4] ^ FLIP;
         assign nibB        = bus.iData_b[gi*4 +: 4] ^ FLIP;
         assign sliceGt[gi] = (nibA > nibB);
         assign sliceEq[gi] = (nibA == nibB);
         assign sliceLt[gi] = (nibA < nibB);
      end
   endgenerate

   logic       gtAcc;
   logic       eqAcc;
   logic       ltAcc;
   logic [2:0] resultNext;
   logic [2:0] resultReg;

   // Walk from the MSB slice down; only a slice below an all-equal prefix may decide.
   always_comb begin
      gtAcc = sliceGt[SLICES-1];
      eqAcc = sliceEq[SLICES-1];
      ltAcc = sliceLt[SLICES-1];
      for (int i = SLICES - 2; i >= 0; i--) begin
         gtAcc = gtAcc | (eqAcc & sliceGt[i]);
         ltAcc = ltAcc | (eqAcc & sliceLt[i]);
         eqAcc = eqAcc & sliceEq[i];
      end
      resultNext = {gtAcc, eqAcc, ltAcc};
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         resultReg <= 3'b000;
      end else begin
         resultReg <= resultNext;
      end
   end

   assign bus.oData = resultReg;
endmodule

// File: tb/tb_data_compare8.sv
// Self-checking bench for data_compare8: directed boundary cases plus random back-to-back traffic.
// The reference model is plain integer comparison; the signedness follows DATA_COMPARE_SIGNED_EN.
`timescale 1ns/1ps
module tb_data_compare8;
   logic clk;
   logic rstN;
   int   checkCount;
   int   errorCount;

   data_compare8_if #(.WIDTH(8)) bus ();

   data_compare8 #(.WIDTH(8), .SLICE_W(4)) dut (
      .iClk   (clk),
      .iRst_n (rstN),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] refCompare(input logic [7:0] a, input logic [7:0] b);
      int ia;
      int ib;
`ifdef DATA_COMPARE_SIGNED_EN
      ia = int'($signed(a));
      ib = int'($signed(b));
`else
      ia = int'(a);
      ib = int'(b);
`endif
      if (ia > ib)       return 3'b100;
      else if (ia == ib) return 3'b010;
      else               return 3'b001;
   endfunction

   task automatic checkResult(input string tag, input logic [2:0] got, input logic [2:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("FAIL %s: oData=%b expected=%b", tag, got, exp);
      end else begin
         $display("ok   %s: oData=%b", tag, got);
      end
   endtask

   // One transaction: present operands at the falling edge, check just after the next rising edge.
   task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      bus.iData_a = a;
      bus.iData_b = b;
      @(posedge clk);
      #1;
      checkResult($sformatf("%s A=%h B=%h", tag, a, b), bus.oData, refCompare(a, b));
   endtask

   logic [7:0] dirA [0:10];
   logic [7:0] dirB [0:10];

   initial begin
      checkCount = 0;
      errorCount = 0;
      dirA = '{8'h00, 8'hF0, 8'h01, 8'h00, 8'hF0, 8'hF1, 8'hD1, 8'hFF, 8'h0F, 8'h80, 8'h7F};
      dirB = '{8'h00, 8'hF0, 8'h00, 8'h01, 8'hF1, 8'hF0, 8'hF0, 8'h00, 8'h10, 8'h7F, 8'h80};

      // Reset asserted away from any edge must clear the output immediately.
      rstN        = 1'b1;
      bus.iData_a = 8'h01;
      bus.iData_b = 8'h00;
      #2;
      rstN = 1'b0;
      #1;
      checkResult("reset immediate", bus.oData, 3'b000);
      repeat (2) @(posedge clk);
      #1;
      checkResult("reset held over edges", bus.oData, 3'b000);
      @(negedge clk);
      rstN = 1'b1;
      @(posedge clk);
      #1;
      checkResult("first edge after release A=01 B=00", bus.oData, 3'b100);

      for (int i = 0; i < 11; i++) begin
         step("directed", dirA[i], dirB[i]);
      end

      // Fixed expectations for the signedness boundary, independent of the model.
`ifdef DATA_COMPARE_SIGNED_EN
      step("signed 80 vs 7F", 8'h80, 8'h7F);
      checkResult("signed 80<7F", bus.oData, 3'b001);
`else
      step("unsigned 80 vs 7F", 8'h80, 8'h7F);
      checkResult("unsigned 80>7F", bus.oData, 3'b100);
`endif

      for (int i = 0; i < 200; i++) begin
         logic [7:0] ra;
         logic [7:0] rb;
         ra = 8'($urandom);
         case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ 8'(1 << $urandom_range(0, 7));
            default: rb = 8'($urandom);
         endcase
         step("random", ra, rb);
      end

      // Mid-stream reset with operands that would otherwise produce a non-zero result.
      @(negedge clk);
      bus.iData_a = 8'hFF;
      bus.iData_b = 8'h00;
      #2;
      rstN = 1'b0;
      #1;
      checkResult("mid-stream reset", bus.oData, 3'b000);
      @(posedge clk);
      #1;
      checkResult("mid-stream reset over edge", bus.oData, 3'b000);
      @(negedge clk);
      rstN = 1'b1;
      step("after mid-stream release", 8'h0F, 8'h10);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
